// File: rtl/dyn_brnch_pred_sat_ghist.sv
// Dynamic branch predictor: table of saturating counters, one pending prediction, misprediction counter.
// Define DYN_BP_GHIST_EN to XOR a non-speculative global history register into the table index (gshare).
module dyn_brnch_pred_sat_ghist #(
    parameter int IDX_W  = 5,
    parameter int CNT_W  = 2,
    parameter int HIST_W = 5,
    parameter int MISS_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_vld,
    input  logic [IDX_W-1:0]  lookup_pc_idx,
    input  logic              stall,
    input  logic              resolve_vld,
    input  logic              resolve_taken,
    output logic              prediction,
    output logic              pend_vld,
    output logic              mispredict,
    output logic [MISS_W-1:0] miss_cnt
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0]  CTR_INIT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]  CTR_MAX  = '1;
    localparam logic [CNT_W-1:0]  CTR_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [MISS_W-1:0] MISS_MAX = '1;
    localparam logic [MISS_W-1:0] MISS_ONE = {{(MISS_W-1){1'b0}}, 1'b1};

    if (CNT_W < 2 || HIST_W < 2 || HIST_W > IDX_W) begin : g_bad_params
        $error("dyn_brnch_pred_sat_ghist: need CNT_W >= 2 and 2 <= HIST_W <= IDX_W");
    end

    // lookup_vld and resolve_vld are single-cycle qualifiers with no backpressure;
    // stall=1 turns both into no-ops for capture, training, history and counting.
    logic [CNT_W-1:0] tbl [DEPTH];
    logic [IDX_W-1:0] pend_idx;
    logic             pend_pred;
    logic             trn;
    logic             cap;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] cur;
    logic [CNT_W-1:0] wr_val;
    logic [CNT_W-1:0] ctr_eff;

    assign trn = resolve_vld & pend_vld & ~stall;
    assign cap = lookup_vld & ~stall;

`ifdef DYN_BP_GHIST_EN
    logic [HIST_W-1:0] ghr;

    // Lookups in a training cycle still hash with the pre-update history.
    assign rd_idx = lookup_pc_idx ^ IDX_W'(ghr);

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (trn) begin
            ghr <= {ghr[HIST_W-2:0], resolve_taken};
        end
    end
`else
    assign rd_idx = lookup_pc_idx;
`endif

    always_comb begin
        cur    = tbl[pend_idx];
        wr_val = cur;
        if (resolve_taken) begin
            if (cur != CTR_MAX) wr_val = cur + CTR_ONE;
        end else begin
            if (cur != '0) wr_val = cur - CTR_ONE;
        end
    end

    // Forward the counter being trained this cycle so a lookup never sees a stale value.
    always_comb begin
        ctr_eff = tbl[rd_idx];
        if (trn && (pend_idx == rd_idx)) ctr_eff = wr_val;
    end

    assign prediction = lookup_vld & ctr_eff[CNT_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= CTR_INIT;
        end else if (trn) begin
            tbl[pend_idx] <= wr_val;
        end
    end

    // Training consumes the old pending entry; a same-cycle capture then replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_idx  <= '0;
            pend_pred <= 1'b0;
        end else if (cap) begin
            pend_vld  <= 1'b1;
            pend_idx  <= rd_idx;
            pend_pred <= prediction;
        end else if (trn) begin
            pend_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict <= 1'b0;
            miss_cnt   <= '0;
        end else begin
            mispredict <= trn & (pend_pred != resolve_taken);
            if (trn && (pend_pred != resolve_taken) && (miss_cnt != MISS_MAX)) begin
                miss_cnt <= miss_cnt + MISS_ONE;
            end
        end
    end
endmodule
